// File: rtl/player_bullet.sv
// Player-shot engine: launches one bullet from the cannon and moves it upward
// on game ticks. Each clock it tests the bullet tip against the invader grid
// and flags a kill for score_logic.
// Optional build macro: SHOT_QUEUE_EN adds a 1-deep pending-shot flag.
//
//   state  | meaning
//   IDLE   | no bullet on screen; a shoot (or pending shot) launches one
//   FLYING | bullet on screen, moving up on ticks, hit-tested every clock
module player_bullet #(
   parameter int PLAYER_Y = 440,
   parameter int PLAYER_W = 32,
   parameter int SPEED    = 4,
   parameter int ROWS     = 5,
   parameter int COLS     = 11,
   parameter int CELL_W   = 32,
   parameter int CELL_H   = 32,
   parameter int INV_W    = 24,
   parameter int INV_H    = 16
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 tick,
   input  logic                 shoot,
   input  logic [9:0]           player_x,
   input  logic [9:0]           grid_x,
   input  logic [9:0]           grid_y,
   input  logic [ROWS*COLS-1:0] alive,
   output logic                 bullet_active,
   output logic [9:0]           bullet_x,
   output logic [9:0]           bullet_y,
   output logic                 invader_collision,
   output logic [5:0]           kill_idx
);

   localparam int CX_SH = $clog2(CELL_W);
   localparam int CY_SH = $clog2(CELL_H);
   localparam int COL_W = 10 - CX_SH;
   localparam int ROW_W = 10 - CY_SH;

   localparam logic [COL_W-1:0] COLS_L     = COL_W'(COLS);
   localparam logic [ROW_W-1:0] ROWS_L     = ROW_W'(ROWS);
   localparam logic [CX_SH-1:0] INV_W_L    = CX_SH'(INV_W);
   localparam logic [CY_SH-1:0] INV_H_L    = CY_SH'(INV_H);
   localparam logic [9:0]       LAUNCH_DX  = 10'(PLAYER_W / 2);
   localparam logic [9:0]       PLAYER_Y_L = 10'(PLAYER_Y);
   localparam logic [9:0]       SPEED_L    = 10'(SPEED);
   localparam logic [5:0]       COLS_I     = 6'(COLS);

   typedef enum logic {IDLE = 1'b0, FLYING = 1'b1} state_t;

   state_t     state_q, state_d;
   logic [9:0] bx_q, bx_d;
   logic [9:0] by_q, by_d;
   logic       coll_q, coll_d;
   logic [5:0] kill_q, kill_d;

   logic [10:0]      dx, dy;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [5:0]       hit_idx;
   logic             in_cell;
   logic             hit;
   logic             launch_req;

   // Grid hit test from registered bullet position; divide/modulo are bit slices.
   always_comb begin
      dx      = {1'b0, bx_q} - {1'b0, grid_x};
      dy      = {1'b0, by_q} - {1'b0, grid_y};
      col     = dx[9:CX_SH];
      row     = dy[9:CY_SH];
      hit_idx = 6'(row) * COLS_I + 6'(col);
      in_cell = !dx[10] && !dy[10] && (col < COLS_L) && (row < ROWS_L) &&
                (dx[CX_SH-1:0] < INV_W_L) && (dy[CY_SH-1:0] < INV_H_L);
      hit     = (state_q == FLYING) && in_cell && alive[hit_idx];
   end

`ifdef SHOT_QUEUE_EN
   logic pend_q, pend_d;

   assign launch_req = shoot | pend_q;

   // A shot fired while the bullet is busy is remembered once; launch clears it.
   always_comb begin
      pend_d = pend_q;
      if (state_q == IDLE) begin
         if (launch_req) pend_d = 1'b0;
      end else if (shoot) begin
         pend_d = 1'b1;
      end
   end

   // Pending-shot flag register.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) pend_q <= 1'b0;
      else      pend_q <= pend_d;
   end
`else
   assign launch_req = shoot;
`endif

   // Next state: launch, hit (wins over tick), move or top exit.
   always_comb begin
      state_d = state_q;
      bx_d    = bx_q;
      by_d    = by_q;
      coll_d  = 1'b0;
      kill_d  = kill_q;
      case (state_q)
         IDLE: begin
            if (launch_req) begin
               state_d = FLYING;
               bx_d    = player_x + LAUNCH_DX;
               by_d    = PLAYER_Y_L;
            end
         end
         FLYING: begin
            if (hit) begin
               state_d = IDLE;
               coll_d  = 1'b1;
               kill_d  = hit_idx;
            end else if (tick) begin
               if (by_q < SPEED_L) state_d = IDLE;
               else                by_d    = by_q - SPEED_L;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= IDLE;
         bx_q    <= '0;
         by_q    <= '0;
         coll_q  <= 1'b0;
         kill_q  <= '0;
      end else begin
         state_q <= state_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         coll_q  <= coll_d;
         kill_q  <= kill_d;
      end
   end

   assign bullet_active     = (state_q == FLYING);
   assign bullet_x          = bx_q;
   assign bullet_y          = by_q;
   assign invader_collision = coll_q;
   assign kill_idx          = kill_q;

endmodule

// File: tb/tb_player_bullet.sv
// Bench for player_bullet: inputs change on the falling edge, a reference model
// pushes the expected post-edge outputs, and a monitor pops and compares them
// one step after every rising edge.
module tb_player_bullet;
   localparam int PLAYER_Y = 440;
   localparam int PLAYER_W = 32;
   localparam int SPEED    = 4;
   localparam int ROWS     = 5;
   localparam int COLS     = 11;
   localparam int CELL_W   = 32;
   localparam int CELL_H   = 32;
   localparam int INV_W    = 24;
   localparam int INV_H    = 16;

   logic        clk = 1'b0;
   logic        arst, tick, shoot;
   logic [9:0]  player_x, grid_x, grid_y;
   logic [54:0] alive;
   logic        bullet_active, invader_collision;
   logic [9:0]  bullet_x, bullet_y;
   logic [5:0]  kill_idx;

   always #5 clk = ~clk;

   player_bullet dut (
      .clk(clk), .arst(arst), .tick(tick), .shoot(shoot),
      .player_x(player_x), .grid_x(grid_x), .grid_y(grid_y), .alive(alive),
      .bullet_active(bullet_active), .bullet_x(bullet_x), .bullet_y(bullet_y),
      .invader_collision(invader_collision), .kill_idx(kill_idx)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [27:0] exp_q[$];
   bit started = 0;

   // Staged inputs, applied on the next falling edge by step().
   logic [9:0]  n_px = '0, n_gx = '0, n_gy = '0;
   logic [54:0] n_al = '0;

   // Reference model state.
   int m_active = 0, m_bx = 0, m_by = 0, m_coll = 0, m_kill = 0, m_pend = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [27:0] dut_outs();
      return {bullet_active, bullet_x, bullet_y, invader_collision, kill_idx};
   endfunction

   // Which live invader sprite rectangle contains the point, or -1.
   function automatic int find_hit(input int bx, input int by);
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            int x0, y0;
            x0 = int'(grid_x) + c * CELL_W;
            y0 = int'(grid_y) + r * CELL_H;
            if (bx >= x0 && bx < x0 + INV_W && by >= y0 && by < y0 + INV_H &&
                alive[r * COLS + c] == 1'b1)
               return r * COLS + c;
         end
      end
      return -1;
   endfunction

   task automatic model_step(input logic a, input logic t, input logic s);
      int h;
      bit qen;
`ifdef SHOT_QUEUE_EN
      qen = 1;
`else
      qen = 0;
`endif
      if (a) begin
         m_active = 0; m_bx = 0; m_by = 0; m_coll = 0; m_kill = 0; m_pend = 0;
         return;
      end
      h = (m_active != 0) ? find_hit(m_bx, m_by) : -1;
      m_coll = 0;
      if (m_active == 0) begin
         if (s || m_pend != 0) begin
            m_active = 1;
            m_bx = (int'(player_x) + PLAYER_W / 2) % 1024;
            m_by = PLAYER_Y;
            m_pend = 0;
         end
      end else begin
         if (s && qen) m_pend = 1;
         if (h >= 0) begin
            m_coll = 1; m_kill = h; m_active = 0;
         end else if (t) begin
            if (m_by < SPEED) m_active = 0;
            else m_by = m_by - SPEED;
         end
      end
   endtask

   task automatic step(input logic a, input logic t, input logic s);
      @(negedge clk);
      arst = a; tick = t; shoot = s;
      player_x = n_px; grid_x = n_gx; grid_y = n_gy; alive = n_al;
      model_step(a, t, s);
      exp_q.push_back({1'(m_active), 10'(m_bx), 10'(m_by), 1'(m_coll), 6'(m_kill)});
      started = 1;
      if (a) begin
         #1;
         chk("arst_immediate", 32'(dut_outs()), 32'd0);
      end
   endtask

   // Fly with a tick every cycle until a kill; check index and the frozen y.
   task automatic fly_to_kill(input string nm, input int exp_idx, input int exp_y);
      bit got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
`ifdef SHOT_QUEUE_EN
         step(1'b0, 1'b1, 1'b0);
`else
         step(1'b0, 1'b1, (i == 5 || i == 20));
`endif
         @(posedge clk); #1;
         if (invader_collision) begin
            got = 1;
            chk({nm, "_kill_idx"}, 32'(kill_idx), 32'(exp_idx));
            chk({nm, "_y_frozen"}, 32'(bullet_y), 32'(exp_y));
            chk({nm, "_active"}, 32'(bullet_active), 32'd0);
         end
      end
      if (!got) begin
         n_checks++;
         $display("FAIL %s_timeout: no kill within 200 cycles, expected idx %0d", nm, exp_idx);
      end
      step(1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk({nm, "_pulse_width"}, 32'(invader_collision), 32'd0);
      chk({nm, "_idx_held"}, 32'(kill_idx), 32'(exp_idx));
   endtask

   task automatic fly_to_exit(input string nm);
      bit gone = 0;
      for (int i = 0; i < 200 && !gone; i++) begin
         step(1'b0, 1'b1, 1'b0);
         @(posedge clk); #1;
         if (!bullet_active) gone = 1;
      end
      if (!gone) begin
         n_checks++;
         $display("FAIL %s_timeout: bullet still active after 200 ticks, expected exit", nm);
      end
   endtask

   // Scoreboard monitor.
   initial begin
      logic [27:0] e;
      forever begin
         @(posedge clk); #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle_outputs", 32'(dut_outs()), 32'(e));
         end else if (started) begin
            n_checks++;
            $display("FAIL scoreboard_empty: got 0x%0h expected a queued entry", dut_outs());
         end
      end
   end

   initial begin
      arst = 1'b1; tick = 1'b0; shoot = 1'b0;
      player_x = '0; grid_x = '0; grid_y = '0; alive = '0;
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("reset_outputs", 32'(dut_outs()), 32'd0);

      // Launch from player_x=100.
      n_px = 10'd100;
      step(1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      chk("launch_active", 32'(bullet_active), 32'd1);
      chk("launch_x", 32'(bullet_x), 32'd116);
      chk("launch_y", 32'(bullet_y), 32'd440);

      // Empty grid: bullet leaves the top with no kill.
      n_al = '0;
      fly_to_exit("top_exit");
      chk("top_exit_no_pulse", 32'(invader_collision), 32'd0);

      // Full grid: lowest row, column 0 (dx=16) is hit first at y=180.
      n_gx = 10'd100; n_gy = 10'd40; n_al = '1;
      step(1'b0, 1'b0, 1'b1);
      fly_to_kill("row4", 44, 180);

      // Row 4 column 0 dead: bullet passes the gap and kills row 3 at y=148.
      n_al = '1; n_al[44] = 1'b0;
      step(1'b0, 1'b0, 1'b1);
      fly_to_kill("row3", 33, 148);

      // Reset mid-flight clears everything at once.
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);

`ifdef SHOT_QUEUE_EN
      n_al = '0;
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      fly_to_exit("queue_first");
      step(1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("queue_relaunch_active", 32'(bullet_active), 32'd1);
      chk("queue_relaunch_y", 32'(bullet_y), 32'd440);
      fly_to_exit("queue_second");
      step(1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("queue_single_relaunch", 32'(bullet_active), 32'd0);
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0) begin
            n_gx = 10'($urandom_range(0, 400));
            n_gy = 10'($urandom_range(0, 300));
            n_al = 55'({$urandom(), $urandom()});
         end
         if ($urandom_range(0, 15) == 0) begin
            int k;
            k = int'($urandom_range(0, 54));
            n_al[k] = ~n_al[k];
         end
         if ($urandom_range(0, 7) == 0) n_px = 10'($urandom_range(0, 1023));
         step($urandom_range(0, 599) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) == 0);
      end

      @(posedge clk); #3;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
